// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX FIFO push port among several requesters.
// A grant covers a whole message. It is released on the last byte, at the burst cap, or on a stall timeout.
module uart_tx_arbiter #(
  parameter int P_NUM_REQ       = 4,
  parameter int P_DATA_WIDTH    = 8,
  parameter int P_MAX_BURST     = 16,
  parameter int P_STALL_TIMEOUT = 64
) (
  input  logic                              iClk,
  input  logic                              iRst,
  input  logic [P_NUM_REQ-1:0]              iReqValid,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] iReqData,
  input  logic [P_NUM_REQ-1:0]              iReqLast,
  output logic [P_NUM_REQ-1:0]              oReqReady,
  output logic                              oPush,
  output logic [P_DATA_WIDTH-1:0]           oPushData,
  input  logic                              iFull,
  output logic [P_NUM_REQ-1:0]              oGrant,
  output logic                              oBusy,
  output logic                              oRelease,
  output logic [1:0]                        oRelCause
);

  localparam int IW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
  localparam int BW = $clog2(P_MAX_BURST + 1);
  localparam int SW = $clog2(P_STALL_TIMEOUT + 1);

  localparam logic [1:0] CAUSE_LAST  = 2'd0;
  localparam logic [1:0] CAUSE_BURST = 2'd1;
  localparam logic [1:0] CAUSE_STALL = 2'd2;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                                   rState, nState;
  logic [IW-1:0]                            rGrantIdx, nGrantIdx, rLastIdx, nLastIdx;
  logic [IW-1:0]                            scan, pick;
  logic                                     found;
  logic [BW-1:0]                            rBeat, nBeat;
  logic [SW-1:0]                            rStall, nStall;
  logic                                     rRelease, nRelease;
  logic [1:0]                               rRelCause, nRelCause;
  logic                                     relNow;
  logic [1:0]                               relCause;
  logic [P_NUM_REQ-1:0][P_DATA_WIDTH-1:0]   reqData;

  for (genvar k = 0; k < P_NUM_REQ; k++) begin : gUnpack
    assign reqData[k] = iReqData[k*P_DATA_WIDTH +: P_DATA_WIDTH];
  end

  // Round-robin scan starts one past the last released requester.
  always_comb begin
    found = 1'b0;
    pick  = rGrantIdx;
    scan  = '0;
    for (int i = 1; i <= P_NUM_REQ; i++) begin
      scan = IW'((int'(rLastIdx) + i) % P_NUM_REQ);
      if (!found && iReqValid[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  always_comb begin
    nState    = rState;
    nGrantIdx = rGrantIdx;
    nLastIdx  = rLastIdx;
    nBeat     = rBeat;
    nStall    = rStall;
    nRelease  = 1'b0;
    nRelCause = 2'd0;
    relNow    = 1'b0;
    relCause  = CAUSE_LAST;
    oReqReady = '0;
    oPush     = 1'b0;
    oPushData = reqData[rGrantIdx];
    case (rState)
      IDLE: begin
        if (found) begin
          nState    = GRANT;
          nGrantIdx = pick;
        end
      end
      GRANT: begin
        oReqReady[rGrantIdx] = !iFull;
        oPush                = iReqValid[rGrantIdx] && !iFull;
        if (oPush) begin
          nBeat  = rBeat + 1'b1;
          nStall = '0;
          if (iReqLast[rGrantIdx]) begin
            relNow   = 1'b1;
            relCause = CAUSE_LAST;
          end else if (rBeat == BW'(P_MAX_BURST - 1)) begin
            relNow   = 1'b1;
            relCause = CAUSE_BURST;
          end
        end else if (!iReqValid[rGrantIdx]) begin
          // Full-with-valid cycles fall through here and leave the stall count alone.
          nStall = rStall + 1'b1;
          if (rStall == SW'(P_STALL_TIMEOUT - 1)) begin
            relNow   = 1'b1;
            relCause = CAUSE_STALL;
          end
        end
        if (relNow) begin
          nState    = IDLE;
          nLastIdx  = rGrantIdx;
          nBeat     = '0;
          nStall    = '0;
          nRelease  = 1'b1;
          nRelCause = relCause;
        end
      end
      default: nState = IDLE;
    endcase
    if (iRst) begin
      oReqReady = '0;
      oPush     = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rState    <= IDLE;
      rGrantIdx <= '0;
      rLastIdx  <= IW'(P_NUM_REQ - 1);
      rBeat     <= '0;
      rStall    <= '0;
      rRelease  <= 1'b0;
      rRelCause <= 2'd0;
    end else begin
      rState    <= nState;
      rGrantIdx <= nGrantIdx;
      rLastIdx  <= nLastIdx;
      rBeat     <= nBeat;
      rStall    <= nStall;
      rRelease  <= nRelease;
      rRelCause <= nRelCause;
    end
  end

  always_comb begin
    oGrant = '0;
    if (rState == GRANT) oGrant[rGrantIdx] = 1'b1;
  end

  assign oBusy     = (rState == GRANT);
  assign oRelease  = rRelease;
  assign oRelCause = rRelCause;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed message scenarios plus random traffic.
// Every cycle is checked against a transaction-level grant/message model.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXB = 16;
  localparam int TMO  = 64;

  logic             iClk = 1'b0;
  logic             iRst;
  logic [N-1:0]     iReqValid;
  logic [N*W-1:0]   iReqData;
  logic [N-1:0]     iReqLast;
  logic [N-1:0]     oReqReady;
  logic             oPush;
  logic [W-1:0]     oPushData;
  logic             iFull;
  logic [N-1:0]     oGrant;
  logic             oBusy;
  logic             oRelease;
  logic [1:0]       oRelCause;

  always #5 iClk = ~iClk;

  uart_tx_arbiter #(
    .P_NUM_REQ(N), .P_DATA_WIDTH(W), .P_MAX_BURST(MAXB), .P_STALL_TIMEOUT(TMO)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iReqValid(iReqValid), .iReqData(iReqData),
    .iReqLast(iReqLast), .oReqReady(oReqReady), .oPush(oPush), .oPushData(oPushData),
    .iFull(iFull), .oGrant(oGrant), .oBusy(oBusy), .oRelease(oRelease), .oRelCause(oRelCause)
  );

  int errCnt = 0;
  int chkCnt = 0;

  // Per-requester byte streams: {last, data}
  logic [W:0]   srcQ [N][$];
  logic [N-1:0] gate;
  logic         fullNow;
  int           obsSrc[$];
  logic [W-1:0] obsData[$];

  // Model: granted requester (-1 when none), last released, message beats, idle run.
  int mG, mLastIdx, mBeats, mIdle, mCause;
  bit mRel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idxOf(input logic [N-1:0] g);
    for (int i = 0; i < N; i++)
      if (g === (N'(1) << i)) return i;
    return -1;
  endfunction

  function automatic bit bitAt(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  task automatic modelReset();
    mG = -1; mLastIdx = N - 1; mBeats = 0; mIdle = 0; mRel = 0; mCause = 0;
  endtask

  task automatic addByte(input int k, input logic [W-1:0] d, input bit last);
    srcQ[k].push_back({last, d});
  endtask

  task automatic hardReset();
    iRst = 1'b1; iReqValid = '0; iReqData = '0; iReqLast = '0; iFull = 1'b0;
    for (int k = 0; k < N; k++) srcQ[k].delete();
    gate = '1; fullNow = 1'b0;
    @(posedge iClk);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    modelReset();
    obsSrc.delete();
    obsData.delete();
  endtask

  // One clock: drive, check outputs against the model, then advance the model past the edge.
  task automatic cycle(input bit rst);
    logic [N-1:0] vld, lst, expRdy, expGnt;
    bit           expPush, relNow;
    int           cause, c;
    vld = '0; lst = '0; iReqData = '0;
    for (int k = 0; k < N; k++)
      if (srcQ[k].size() > 0 && gate[k]) begin
        vld = vld | (N'(1) << k);
        if (srcQ[k][0][W]) lst = lst | (N'(1) << k);
        iReqData[k*W +: W] = srcQ[k][0][W-1:0];
      end
    iRst = rst; iReqValid = vld; iReqLast = lst; iFull = fullNow;
    #2;
    expGnt  = (mG >= 0) ? (N'(1) << mG) : '0;
    expPush = (mG >= 0) && bitAt(vld, mG) && !fullNow && !rst;
    expRdy  = ((mG >= 0) && !fullNow && !rst) ? (N'(1) << mG) : '0;
    chk("grant", 32'(oGrant), 32'(expGnt));
    chk("busy", 32'(oBusy), 32'(mG >= 0));
    chk("ready", 32'(oReqReady), 32'(expRdy));
    chk("push", 32'(oPush), 32'(expPush));
    if (expPush) chk("pushData", 32'(oPushData), 32'(srcQ[mG][0][W-1:0]));
    chk("release", 32'(oRelease), 32'(mRel));
    if (mRel) chk("relCause", 32'(oRelCause), 32'(mCause));
    if (oPush === 1'b1) begin
      obsSrc.push_back(idxOf(oGrant));
      obsData.push_back(oPushData);
    end
    relNow = 0; cause = 0;
    if (rst) modelReset();
    else begin
      mRel = 0; mCause = 0;
      if (mG < 0) begin
        for (int i = 1; i <= N; i++) begin
          c = (mLastIdx + i) % N;
          if (bitAt(vld, c)) begin mG = c; break; end
        end
      end else if (expPush) begin
        void'(srcQ[mG].pop_front());
        mBeats++; mIdle = 0;
        if (bitAt(lst, mG)) begin relNow = 1; cause = 0; end
        else if (mBeats == MAXB) begin relNow = 1; cause = 1; end
      end else if (!bitAt(vld, mG)) begin
        mIdle++;
        if (mIdle == TMO) begin relNow = 1; cause = 2; end
      end
      if (relNow) begin
        mLastIdx = mG; mG = -1; mBeats = 0; mIdle = 0; mRel = 1; mCause = cause;
      end
    end
    @(posedge iClk);
    #1;
  endtask

  function automatic bit pending();
    bit p = (mG >= 0) || mRel;
    for (int k = 0; k < N; k++) if (srcQ[k].size() > 0) p = 1;
    return p;
  endfunction

  task automatic runUntilIdle(input string tag, input int bound);
    int n = 0;
    while (pending() && n < bound) begin cycle(0); n++; end
    chk({tag, "_drain"}, 32'(n < bound), 32'd1);
  endtask

  task automatic runUntilPushes(input string tag, input int cnt, input int bound);
    int n = 0;
    while (obsData.size() < cnt && n < bound) begin cycle(0); n++; end
    chk({tag, "_wait"}, 32'(n < bound), 32'd1);
  endtask

  task automatic chkSrc(input string tag, input int exp[$]);
    chk({tag, "_count"}, 32'(obsSrc.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < obsSrc.size(); i++)
      chk({tag, "_src"}, 32'(obsSrc[i]), 32'(exp[i]));
  endtask

  initial begin
    int           expS[$];
    logic [W-1:0] sent[$];
    int           len;
    bit           withLast;

    // Single short message from requester 1
    hardReset();
    addByte(1, 8'h41, 0); addByte(1, 8'h42, 0); addByte(1, 8'h43, 1);
    runUntilIdle("t1", 50);
    expS = {1, 1, 1};
    chkSrc("t1", expS);
    for (int i = 0; i < 3 && i < obsData.size(); i++)
      chk("t1_data", 32'(obsData[i]), 32'h41 + 32'(i));

    // All four with 2-byte messages: round-robin order, no interleaving
    hardReset();
    for (int k = 0; k < N; k++) begin
      addByte(k, W'(8'h10 * k), 0);
      addByte(k, W'(8'h10 * k + 1), 1);
    end
    runUntilIdle("t2", 100);
    expS = {0, 0, 1, 1, 2, 2, 3, 3};
    chkSrc("t2", expS);

    // Burst cap: requester 0 streams 20 bytes, requester 2 waits
    hardReset();
    for (int i = 0; i < 20; i++) addByte(0, W'(i), 0);
    addByte(2, 8'hA0, 0); addByte(2, 8'hA1, 1);
    runUntilIdle("t3", 300);
    expS.delete();
    for (int i = 0; i < 16; i++) expS.push_back(0);
    expS.push_back(2); expS.push_back(2);
    for (int i = 0; i < 4; i++) expS.push_back(0);
    chkSrc("t3", expS);

    // Stall timeout: requester 3 sends one byte then goes quiet
    hardReset();
    addByte(3, 8'h33, 0);
    runUntilIdle("t4", 200);
    chk("t4_busy", 32'(oBusy), 32'd0);

    // FIFO full for 100 cycles mid-message
    hardReset();
    sent.delete();
    for (int i = 0; i < 6; i++) begin
      sent.push_back(W'(8'hC0 + i));
      addByte(1, W'(8'hC0 + i), i == 5);
    end
    runUntilPushes("t5", 2, 50);
    fullNow = 1'b1;
    repeat (100) cycle(0);
    fullNow = 1'b0;
    runUntilIdle("t5", 100);
    chk("t5_count", 32'(obsData.size()), 32'd6);
    for (int i = 0; i < 6 && i < obsData.size(); i++)
      chk("t5_data", 32'(obsData[i]), 32'(sent[i]));

    // Reset pulse while requester 2 holds a valid beat
    hardReset();
    for (int i = 0; i < 5; i++) addByte(2, W'(8'h50 + i), i == 4);
    runUntilPushes("t6", 2, 50);
    cycle(1);
    obsSrc.delete();
    obsData.delete();
    addByte(0, 8'h77, 1);
    runUntilIdle("t6", 100);
    expS = {0, 2, 2, 2};
    chkSrc("t6", expS);

    // Random traffic
    hardReset();
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < N; k++) begin
        if (srcQ[k].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = int'($urandom_range(1, 20));
          withLast = $urandom_range(0, 7) != 0;
          for (int i = 0; i < len; i++)
            addByte(k, W'($urandom), withLast && (i == len - 1));
        end
        gate[k] = $urandom_range(0, 9) != 0;
      end
      fullNow = $urandom_range(0, 6) == 0;
      cycle($urandom_range(0, 499) == 0);
    end
    gate = '1;
    fullNow = 1'b0;
    runUntilIdle("rand", 3000);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
